// File: rtl/sram_ctrl_pkg.sv
// Shared types and elaboration helpers for the asynchronous SRAM controller.
// Imported by the top and the wait-counter sub-module.
package sram_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  // A counter must hold at least one bit even when the maximum wait is zero.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl_wait_ctr.sv
// Loadable down-counter that saturates at zero and flags when it is there.
// Used for both the access-phase timing and the post-read turnaround.
module sram_ctrl_wait_ctr
  import sram_ctrl_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sram_async_ctrl.sv
// Single-outstanding request port to asynchronous SRAM pin sequencer.
// Every pad-facing output is registered; strobes are derived from the next state.
module sram_async_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int W_DATA       = 16,
  parameter int W_ADDR       = 18,
  parameter int N_RD_WAIT    = 1,
  parameter int N_WR_WAIT    = 0,
  parameter int N_TURNAROUND = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [W_ADDR-1:0]        req_addr,
  input  logic [W_DATA-1:0]        req_wdata,
  input  logic [W_DATA/BYTE_W-1:0] req_bytemask,
  output logic                     rsp_valid,
  output logic [W_DATA-1:0]        rsp_rdata,
  output logic [W_ADDR-1:0]        sram_a,
  output logic [W_DATA-1:0]        sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [W_DATA-1:0]        sram_dq_in,
  output logic                     sram_csn,
  output logic                     sram_oen,
  output logic                     sram_wen,
  output logic [W_DATA/BYTE_W-1:0] sram_ben_n
);

  localparam int W_BEN = W_DATA / BYTE_W;
  localparam int W_ACC = ctr_width(max2(N_RD_WAIT, N_WR_WAIT));
  localparam int W_TA  = ctr_width(N_TURNAROUND);

  if (W_DATA % BYTE_W != 0 || W_DATA < BYTE_W) begin : g_bad_wdata
    $error("sram_async_ctrl: W_DATA must be a non-zero multiple of 8");
  end
  if (W_ADDR < 1) begin : g_bad_waddr
    $error("sram_async_ctrl: W_ADDR must be at least 1");
  end

  state_t             state_reg, state_next;
  logic               accept, rd_done;
  logic               acc_load, acc_zero, ta_load, ta_zero;
  logic [W_ACC-1:0]   acc_load_val;

  logic               csn_reg, csn_next, oen_reg, oen_next, wen_reg, wen_next;
  logic               dq_oe_reg, dq_oe_next, rsp_valid_reg, rsp_valid_next;
  logic [W_BEN-1:0]   ben_n_reg, ben_n_next;
  logic [W_ADDR-1:0]  a_reg, a_next;
  logic [W_DATA-1:0]  dq_out_reg, dq_out_next, rdata_reg, rdata_next;

  // Writes wait out the turnaround so the pads never fight the SRAM's output drivers.
  assign req_ready = (state_reg == ST_IDLE) && !(req_write && !ta_zero);
  assign accept    = req_valid && req_ready;
  assign rd_done   = (state_reg == ST_READ) && acc_zero;

  assign acc_load     = (accept && !req_write) || (state_reg == ST_WR_SETUP);
  assign acc_load_val = (state_reg == ST_WR_SETUP) ? W_ACC'(N_WR_WAIT) : W_ACC'(N_RD_WAIT);
  assign ta_load      = rd_done;

  sram_ctrl_wait_ctr #(.W(W_ACC)) u_acc_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (acc_load),
    .load_val (acc_load_val),
    .zero     (acc_zero)
  );

  sram_ctrl_wait_ctr #(.W(W_TA)) u_ta_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ta_load),
    .load_val (W_TA'(N_TURNAROUND)),
    .zero     (ta_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      csn_reg       <= 1'b1;
      oen_reg       <= 1'b1;
      wen_reg       <= 1'b1;
      dq_oe_reg     <= 1'b0;
      ben_n_reg     <= '1;
      a_reg         <= '0;
      dq_out_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      csn_reg       <= csn_next;
      oen_reg       <= oen_next;
      wen_reg       <= wen_next;
      dq_oe_reg     <= dq_oe_next;
      ben_n_reg     <= ben_n_next;
      a_reg         <= a_next;
      dq_out_reg    <= dq_out_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:     if (accept) state_next = req_write ? ST_WR_SETUP : ST_READ;
      ST_READ:     if (acc_zero) state_next = ST_IDLE;
      ST_WR_SETUP: state_next = ST_WR_PULSE;
      ST_WR_PULSE: if (acc_zero) state_next = ST_WR_HOLD;
      ST_WR_HOLD:  state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Address and data only change on acceptance, so WEn can never fall with them.
  always_comb begin
    csn_next       = (state_next == ST_IDLE);
    oen_next       = (state_next != ST_READ);
    wen_next       = (state_next != ST_WR_PULSE);
    dq_oe_next     = (state_next == ST_WR_SETUP) || (state_next == ST_WR_PULSE) ||
                     (state_next == ST_WR_HOLD);
    rsp_valid_next = rd_done || (state_reg == ST_WR_HOLD);
    ben_n_next     = (state_next == ST_IDLE) ? '1 : ben_n_reg;
    a_next         = a_reg;
    dq_out_next    = dq_out_reg;
    rdata_next     = rd_done ? sram_dq_in : rdata_reg;
    if (accept) begin
      a_next = req_addr;
      if (req_write) begin
        dq_out_next = req_wdata;
        ben_n_next  = ~req_bytemask;
      end else begin
        ben_n_next  = '0;
      end
    end
  end

  assign sram_csn    = csn_reg;
  assign sram_oen    = oen_reg;
  assign sram_wen    = wen_reg;
  assign sram_dq_oe  = dq_oe_reg;
  assign sram_ben_n  = ben_n_reg;
  assign sram_a      = a_reg;
  assign sram_dq_out = dq_out_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rdata_reg;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed and randomised checks of sram_async_ctrl against behavioural SRAM models,
// one default-configuration instance and one wide/slow instance.
module tb_sram_async_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default configuration instance
  logic        req_valid0 = 0, req_write0 = 0, req_ready0, rsp_valid0;
  logic [17:0] req_addr0 = '0, a0;
  logic [15:0] req_wdata0 = '0, rsp_rdata0, dq_out0, dq_in0;
  logic [1:0]  req_bytemask0 = '0, ben_n0;
  logic        dq_oe0, csn0, oen0, wen0;

  // wide / slow instance
  logic        req_valid1 = 0, req_write1 = 0, req_ready1, rsp_valid1;
  logic [19:0] req_addr1 = '0, a1;
  logic [31:0] req_wdata1 = '0, rsp_rdata1, dq_out1, dq_in1;
  logic [3:0]  req_bytemask1 = '0, ben_n1;
  logic        dq_oe1, csn1, oen1, wen1;

  sram_async_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .req_bytemask(req_bytemask0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .sram_a(a0), .sram_dq_out(dq_out0), .sram_dq_oe(dq_oe0), .sram_dq_in(dq_in0),
    .sram_csn(csn0), .sram_oen(oen0), .sram_wen(wen0), .sram_ben_n(ben_n0)
  );

  sram_async_ctrl #(.W_DATA(32), .W_ADDR(20), .N_RD_WAIT(3), .N_WR_WAIT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .req_bytemask(req_bytemask1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .sram_a(a1), .sram_dq_out(dq_out1), .sram_dq_oe(dq_oe1), .sram_dq_in(dq_in1),
    .sram_csn(csn1), .sram_oen(oen1), .sram_wen(wen1), .sram_ben_n(ben_n1)
  );

  // behavioural asynchronous SRAMs
  logic [15:0] mem0 [0:(1<<18)-1];
  logic [31:0] mem1 [0:(1<<20)-1];
  logic        pl_en = 0;
  logic [17:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign dq_in0 = (!csn0 && !oen0) ? mem0[a0] : 16'h0000;
  assign dq_in1 = (!csn1 && !oen1) ? mem1[a1] : 32'h0000_0000;

  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
    end else if (!csn0 && !wen0 && dq_oe0) begin
      for (int i = 0; i < 2; i++)
        if (!ben_n0[i]) mem0[a0][8*i +: 8] <= dq_out0[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (!csn1 && !wen1 && dq_oe1) begin
      for (int i = 0; i < 4; i++)
        if (!ben_n1[i]) mem1[a1][8*i +: 8] <= dq_out1[8*i +: 8];
    end
  end

  // pin-level invariant monitor and completion counter for dut0
  int   viol0 = 0, rsp_cnt0 = 0;
  logic wen0_q = 1'b1;
  logic [17:0] a0_q = '0;
  logic [15:0] dq0_q = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((!oen0 && dq_oe0) || (!wen0 && wen0_q && (a0 != a0_q || dq_out0 != dq0_q)))
        viol0 <= viol0 + 1;
      if (rsp_valid0) rsp_cnt0 <= rsp_cnt0 + 1;
    end
    wen0_q <= wen0;
    a0_q   <= a0;
    dq0_q  <= dq_out0;
  end

  a_no_overlap0: assert property (@(posedge clk) disable iff (!rst_n) !(!oen0 && dq_oe0));
  a_no_overlap1: assert property (@(posedge clk) disable iff (!rst_n) !(!oen1 && dq_oe1));
  a_turnaround0: assert property (@(posedge clk) disable iff (!rst_n)
                                  $rose(dq_oe0) |-> ($past(oen0, 1) && $past(oen0, 2)));

  int n_vec = 0, n_err = 0, n_req0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // muxed view of whichever instance the current transaction targets
  int          dsel = 0;
  logic        m_ready, m_rsp_valid, m_csn, m_oen, m_wen;
  logic [31:0] m_rdata;
  logic [3:0]  m_ben_n;
  always_comb begin
    if (dsel == 0) begin
      m_ready = req_ready0; m_rsp_valid = rsp_valid0; m_csn = csn0; m_oen = oen0;
      m_wen = wen0; m_rdata = {16'h0, rsp_rdata0}; m_ben_n = {2'b00, ben_n0};
    end else begin
      m_ready = req_ready1; m_rsp_valid = rsp_valid1; m_csn = csn1; m_oen = oen1;
      m_wen = wen1; m_rdata = rsp_rdata1; m_ben_n = ben_n1;
    end
  end

  task automatic drive(input int sel, input bit v, input bit wr, input logic [19:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    if (sel == 0) begin
      req_valid0 = v; req_write0 = wr; req_addr0 = addr[17:0];
      req_wdata0 = wdata[15:0]; req_bytemask0 = mask[1:0];
    end else begin
      req_valid1 = v; req_write1 = wr; req_addr1 = addr;
      req_wdata1 = wdata; req_bytemask1 = mask;
    end
  endtask

  int          t_lat, t_waits, t_csn_lo, t_oen_lo, t_wen_lo;
  logic [3:0]  t_ben_setup;

  task automatic do_req(input int sel, input bit wr, input logic [19:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata);
    bit acc = 0;
    dsel = sel;
    t_lat = 0; t_waits = 0; t_csn_lo = 0; t_oen_lo = 0; t_wen_lo = 0;
    rdata = '0;
    if (sel == 0) n_req0++;
    @(negedge clk);
    drive(sel, 1'b1, wr, addr, wdata, mask);
    while (!acc && t_waits < 20) begin
      #1;
      if (m_ready) acc = 1;
      else begin
        t_waits++;
        @(negedge clk);
      end
    end
    if (!acc) begin
      chk("accept_timeout", {31'b0, m_ready}, 32'd1);
      drive(sel, 1'b0, wr, addr, wdata, mask);
      return;
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, wr, addr, wdata, mask);
    t_ben_setup = m_ben_n;
    while (!m_rsp_valid && t_lat < 50) begin
      if (!m_csn) t_csn_lo++;
      if (!m_oen) t_oen_lo++;
      if (!m_wen) t_wen_lo++;
      @(posedge clk); #1;
      t_lat++;
    end
    chk("rsp_seen", {31'b0, m_rsp_valid}, 32'd1);
    rdata = m_rdata;
    $display("txn dut%0d %s a=0x%0h wd=0x%0h m=0x%0h rd=0x%0h lat=%0d waits=%0d",
             sel, wr ? "WR" : "RD", addr, wdata, mask, rdata, t_lat, t_waits);
  endtask

  logic [15:0] exp_mem [0:63];

  initial begin
    logic [31:0] rd;

    // preload while reset is held
    repeat (2) @(negedge clk);
    pl_en = 1;
    pl_addr = 18'h12345; pl_data = 16'hBEEF; @(negedge clk);
    pl_addr = 18'h00010; pl_data = 16'h1234; @(negedge clk);
    pl_addr = 18'h00020; pl_data = 16'h7777; @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      exp_mem[i] = 16'(i * 16'h0301) ^ 16'h5AA5;
      pl_addr = 18'h00100 + 18'(i); pl_data = exp_mem[i];
      @(negedge clk);
    end
    pl_en = 0;

    chk("rst_csn", {31'b0, csn0}, 1);
    chk("rst_oen", {31'b0, oen0}, 1);
    chk("rst_wen", {31'b0, wen0}, 1);
    chk("rst_ben_n", {30'b0, ben_n0}, 32'h3);
    chk("rst_dq_oe", {31'b0, dq_oe0}, 0);
    chk("rst_a", {14'b0, a0}, 0);
    chk("rst_dq_out", {16'b0, dq_out0}, 0);
    chk("rst_rsp", {31'b0, rsp_valid0}, 0);
    chk("rst_rdata", {16'b0, rsp_rdata0}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // default read
    do_req(0, 0, 20'h12345, 0, 0, rd);
    chk("rd_data", rd, 32'hBEEF);
    chk("rd_lat", t_lat, 2);
    chk("rd_csn_lo", t_csn_lo, 2);
    chk("rd_oen_lo", t_oen_lo, 2);
    chk("rd_ben_n", {28'b0, t_ben_setup}, 0);

    // masked write: only the low byte lands
    do_req(0, 1, 20'h00010, 32'hA55A, 4'h1, rd);
    chk("wr_lat", t_lat, 3);
    chk("wr_wen_lo", t_wen_lo, 1);
    chk("wr_csn_lo", t_csn_lo, 3);
    chk("wr_oen_lo", t_oen_lo, 0);
    chk("wr_ben_n", {28'b0, t_ben_setup}, 32'h2);
    chk("wr_rdata_hold", rd, 32'hBEEF);

    // read then immediate write: one blocked IDLE cycle
    do_req(0, 0, 20'h00010, 0, 0, rd);
    chk("rb_data", rd, 32'h125A);
    do_req(0, 1, 20'h00020, 32'h0000, 4'h0, rd);
    chk("ta_waits", t_waits, 1);
    chk("mask0_ben_n", {28'b0, t_ben_setup}, 32'h3);
    chk("mask0_lat", t_lat, 3);
    do_req(0, 0, 20'h00020, 0, 0, rd);
    chk("mask0_rb", rd, 32'h7777);
    do_req(0, 0, 20'h12345, 0, 0, rd);
    chk("rd_rd_waits", t_waits, 0);
    chk("rd_rd_data", rd, 32'hBEEF);

    // wide / slow configuration
    do_req(1, 1, 20'hFFFFF, 32'hDEADBEEF, 4'hF, rd);
    chk("w32_wr_lat", t_lat, 5);
    chk("w32_wen_lo", t_wen_lo, 3);
    chk("w32_ben_n", {28'b0, t_ben_setup}, 0);
    do_req(1, 0, 20'hFFFFF, 0, 0, rd);
    chk("w32_rd_lat", t_lat, 4);
    chk("w32_csn_lo", t_csn_lo, 4);
    chk("w32_rd_data", rd, 32'hDEADBEEF);

    // reset in the middle of the write pulse
    dsel = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 20'h00030, 32'hFFFF, 4'h3);
    #1 chk("arst_ready", {31'b0, req_ready0}, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 20'h00030, 32'hFFFF, 4'h3);
    @(posedge clk); #1;
    chk("arst_pre_wen", {31'b0, wen0}, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_wen", {31'b0, wen0}, 1);
    chk("arst_csn", {31'b0, csn0}, 1);
    chk("arst_dq_oe", {31'b0, dq_oe0}, 0);
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk);
    #1 chk("arst_no_rsp", rsp_cnt0, n_req0);
    do_req(0, 0, 20'h12345, 0, 0, rd);
    chk("arst_rd_data", rd, 32'hBEEF);
    chk("arst_rd_lat", t_lat, 2);

    // random mixed traffic against the scoreboard
    for (int n = 0; n < 10000; n++) begin
      int          idx;
      bit          wr;
      logic [15:0] wd;
      logic [1:0]  mk;
      idx = $urandom_range(0, 63);
      wr  = 1'($urandom_range(0, 1));
      wd  = 16'($urandom);
      mk  = 2'($urandom_range(0, 3));
      do_req(0, wr, 20'h00100 + 20'(idx), {16'h0, wd}, {2'b00, mk}, rd);
      if (wr) begin
        for (int b = 0; b < 2; b++)
          if (mk[b]) exp_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        chk("rnd_rd", rd, {16'h0, exp_mem[idx]});
      end
    end

    @(negedge clk); #1;
    chk("rsp_count", rsp_cnt0, n_req0);
    chk("pin_invariants", viol0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_async_ctrl.md
Name: sram_async_ctrl

Overview:
- Clocked controller that converts a single-outstanding valid/ready request port into cycle-accurate pin sequencing for an external asynchronous SRAM: address, data, CSn, OEn, WEn and per-byte enables.
- Parametrised in data width, address width and read/write/turnaround timing.
- Sits between the system bus bridge and the chip pads; pad tristate buffers live outside this block.

Parameters:
- W_DATA, 16, SRAM data width in bits; must be a multiple of 8.
- W_ADDR, 18, SRAM word address width.
- N_RD_WAIT, 1, extra read cycles beyond the first (read access = N_RD_WAIT+1 cycles).
- N_WR_WAIT, 0, extra cycles with WEn low beyond the first.
- N_TURNAROUND, 1, idle cycles required after a read before DQ may be driven.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  W_ADDR  word address.
- req_wdata  in  W_DATA  write data.
- req_bytemask  in  W_DATA/8  write byte lanes; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  W_DATA  read data, valid with rsp_valid after a read.
- sram_a  out  W_ADDR  address pins.
- sram_dq_out  out  W_DATA  data to pads.
- sram_dq_oe  out  1  pad output enable.
- sram_dq_in  in  W_DATA  data from pads.
- sram_csn, sram_oen, sram_wen  out  1 each  active-low strobes.
- sram_ben_n  out  W_DATA/8  active-low byte enables; lane 0 = LSB.

Behaviour:
- Clocking and outputs
  - Single clock domain (clk); rst_n asynchronous active-low. All outputs registered.
  - Reset values: csn/oen/wen = 1, ben_n all 1, dq_oe = 0, sram_a = 0, dq_out = 0, rsp_valid = 0, rsp_rdata = 0.
  - Reset asserted mid-access returns every output to its reset value immediately, abandoning the access; no rsp_valid.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
- req_ready
  - High only in IDLE, except low when req_write = 1 and the turnaround counter ≠ 0.
  - May depend on req_valid/req_write; must never depend on rsp state.
- IDLE
  - csn/oen/wen = 1, ben_n all 1, dq_oe = 0.
  - sram_a holds its last value.
  - Turnaround counter decrements to 0.
- Read: on acceptance edge E0
  - sram_a = req_addr, csn = 0, oen = 0, ben_n = 0, go to READ.
  - Stay in READ for N_RD_WAIT+1 cycles; on the final edge, capture sram_dq_in into rsp_rdata, pulse rsp_valid for one cycle, return to IDLE.
  - Load the turnaround counter with N_TURNAROUND.
  - Read latency from E0 to rsp_valid = N_RD_WAIT+1 cycles.
- Write: on acceptance
  - WR_SETUP (1 cycle): sram_a, dq_out = req_wdata, dq_oe = 1, csn = 0, ben_n = ~req_bytemask, wen = 1.
  - WR_PULSE (N_WR_WAIT+1 cycles): wen = 0.
  - WR_HOLD (1 cycle): wen = 1; address, data, dq_oe and csn unchanged.
  - After WR_HOLD: rsp_valid pulses with rsp_rdata unchanged; go to IDLE.
  - Write total = N_WR_WAIT+3 cycles.
- Timing invariants
  - wen never falls in the same cycle that address or data change.
  - oen = 0 and dq_oe = 1 never coexist.
- Edge cases
  - A write with bytemask = 0 runs the full sequence with ben_n all 1; this is a no-op on the SRAM but still completes with rsp_valid.
  - A request accepted in the same cycle rsp_valid is high is legal: back-to-back reads give one IDLE cycle between accesses.
  - N_TURNAROUND = 0 permits a write in the first IDLE cycle after a read.
- Counters are sized $clog2(max wait + 1); saturate at 0.

Decomposition:
- Shared package sram_ctrl_pkg:
  - state encoding enum.
  - Derived localparams: W_BEN = W_DATA/8, counter widths.
  - Elaboration-time checks: W_DATA % 8 == 0, W_ADDR ≥ 1.
- Natural sub-module sram_ctrl_wait_ctr: loadable down-counter with zero flag. One instance for access timing, one for turnaround.
- Pad muxing stays in chip_top.

Test Plan:
- Defaults, read addr 0x12345 with SRAM model preloaded 0xBEEF → csn/oen low for exactly 2 cycles, rsp_valid 2 cycles after accept, rsp_rdata = 0xBEEF.
- Write addr 0x00010, data 0xA55A, mask 2'b01 → SETUP/PULSE/HOLD = 1/1/1 cycles, ben_n = 2'b10, wen low 1 cycle. Readback = 0xXX5A with upper byte unchanged.
- Read followed by write requested immediately (N_TURNAROUND = 1) → req_ready low one IDLE cycle. dq_oe rises no earlier than 2 cycles after oen rises; no oen/dq_oe overlap, checked by assertion.
- N_RD_WAIT = 3, N_WR_WAIT = 2, W_DATA = 32, W_ADDR = 20, write-then-read of 0xDEADBEEF at 0xFFFFF → read latency 4, wen low 3 cycles, data matches.
- rst_n pulsed low during WR_PULSE → wen, csn and dq_oe go high/low asynchronously, no rsp_valid. The next accepted read completes normally.
- Random 10k mixed requests with random masks against the SRAM model, with a scoreboard → all reads match expected and every request yields exactly one rsp_valid.
